counter_interact_ctrl: RTL and testbench

//  Consumer of the nearest-counter coordinates. On each interact key press it

---
 rtl/overcooked_pkg.sv | 23 ++
 rtl/counter_slot_decode.sv | 34 +++
 rtl/counter_interact_ctrl.sv | 153 +++++++++++++++
 tb/tb_counter_interact_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/overcooked_pkg.sv
// Shared types and constants for the kitchen counter logic.
// Includes the item codes, the interact FSM states and the no-counter sentinel.
package overcooked_pkg;

  typedef enum logic [2:0] {
    ITEM_EMPTY   = 3'd0,
    ITEM_FISH    = 3'd1,
    ITEM_CHOPPED = 3'd2,
    ITEM_COOKED  = 3'd3,
    ITEM_PLATED  = 3'd4
  } item_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    ACT      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [9:0]  NO_COUNTER = 10'd15;
  localparam int unsigned SLOT_W     = 4;

endpackage

// File: rtl/counter_slot_decode.sv
// Maps a counter centre (X,Y) onto a top-wall slot index.
// Uses a constant-compare chain so no divider is inferred; shared with the renderer highlight.
module counter_slot_decode
  import overcooked_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned SLOT_PITCH  = 40,
  parameter int unsigned SLOT_OFFSET = 20,
  parameter logic [9:0]  COUNTER_Y   = 10'd100
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              slot_valid,
  output logic [SLOT_W-1:0] slot_idx
);

  logic sentinel;

  assign sentinel = (x == NO_COUNTER) && (y == NO_COUNTER);

  always_comb begin
    slot_valid = 1'b0;
    slot_idx   = '0;
    if (!sentinel && (y == COUNTER_Y)) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (x == 10'(SLOT_OFFSET + i * SLOT_PITCH)) begin
          slot_valid = 1'b1;
          slot_idx   = SLOT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/counter_interact_ctrl.sv
// Interact-key handler: picks up from / places onto the selected top-wall counter.
// Owns the per-counter item table, the held item and the delivered-dish score.
module counter_interact_ctrl
  import overcooked_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 16,
  parameter int unsigned SLOT_PITCH     = 40,
  parameter int unsigned SLOT_OFFSET    = 20,
  parameter logic [9:0]  COUNTER_Y      = 10'd100,
  parameter int unsigned DISPENSER_SLOT = 0,
  parameter int unsigned SERVE_SLOT     = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        nearestCounterX,
  input  logic [9:0]        nearestCounterY,
  input  logic              interactKey,
  input  logic [SLOT_W-1:0] renderSlot,
  output logic [2:0]        renderItem,
  output logic [2:0]        heldItem,
  output logic              busy,
  output logic              serveStrobe,
  output logic [7:0]        score
);

  localparam logic [SLOT_W-1:0] DISP_IDX  = SLOT_W'(DISPENSER_SLOT);
  localparam logic [SLOT_W-1:0] SERVE_IDX = SLOT_W'(SERVE_SLOT);

  state_t            state_q, state_d;
  logic              key_prev_q;
  logic [9:0]        x_q, y_q;
  logic              slot_valid_q;
  logic [SLOT_W-1:0] slot_idx_q;
  logic              dec_valid;
  logic [SLOT_W-1:0] dec_idx;
  item_t             held_q, held_d;
  logic [7:0]        score_q, score_d;
  logic              serve_strobe_q, strobe_d;
  item_t             table_q [NUM_SLOTS];
  item_t             slot_item;
  logic              tbl_we;
  item_t             tbl_wdata;
  logic              press;
  logic              latch_xy;

  counter_slot_decode #(
    .NUM_SLOTS   (NUM_SLOTS),
    .SLOT_PITCH  (SLOT_PITCH),
    .SLOT_OFFSET (SLOT_OFFSET),
    .COUNTER_Y   (COUNTER_Y)
  ) u_decode (
    .x          (x_q),
    .y          (y_q),
    .slot_valid (dec_valid),
    .slot_idx   (dec_idx)
  );

  assign press     = interactKey & ~key_prev_q;
  assign slot_item = table_q[slot_idx_q];

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    score_d   = score_q;
    strobe_d  = 1'b0;
    tbl_we    = 1'b0;
    tbl_wdata = ITEM_EMPTY;
    latch_xy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          latch_xy = 1'b1;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: state_d = ACT;
      ACT: begin
        state_d = WAIT_REL;
        // Dispenser and serve slots are special-cased ahead of the generic swap
        if (slot_valid_q) begin
          if (slot_idx_q == DISP_IDX) begin
            if (held_q == ITEM_EMPTY) held_d = ITEM_FISH;
          end else if (slot_idx_q == SERVE_IDX) begin
            if (held_q == ITEM_PLATED) begin
              held_d   = ITEM_EMPTY;
              score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              strobe_d = 1'b1;
            end
          end else if ((held_q == ITEM_EMPTY) && (slot_item != ITEM_EMPTY)) begin
            held_d    = slot_item;
            tbl_we    = 1'b1;
            tbl_wdata = ITEM_EMPTY;
          end else if ((held_q != ITEM_EMPTY) && (slot_item == ITEM_EMPTY)) begin
            held_d    = ITEM_EMPTY;
            tbl_we    = 1'b1;
            tbl_wdata = held_q;
          end
        end
      end
      WAIT_REL: begin
        if (!interactKey) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      key_prev_q     <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      slot_valid_q   <= 1'b0;
      slot_idx_q     <= '0;
      held_q         <= ITEM_EMPTY;
      score_q        <= '0;
      serve_strobe_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_prev_q     <= interactKey;
      held_q         <= held_d;
      score_q        <= score_d;
      serve_strobe_q <= strobe_d;
      if (latch_xy) begin
        x_q <= nearestCounterX;
        y_q <= nearestCounterY;
      end
      if (state_q == LOOKUP) begin
        slot_valid_q <= dec_valid;
        slot_idx_q   <= dec_idx;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) table_q[i] <= ITEM_EMPTY;
    end else if (tbl_we) begin
      table_q[slot_idx_q] <= tbl_wdata;
    end
  end

  always_comb begin
    renderItem = ITEM_EMPTY;
    if ({1'b0, renderSlot} < 5'(NUM_SLOTS)) renderItem = table_q[renderSlot];
  end

  assign heldItem    = held_q;
  assign busy        = (state_q != IDLE);
  assign serveStrobe = serve_strobe_q;
  assign score       = score_q;

endmodule

// File: tb/tb_counter_interact_ctrl.sv
// Directed plus randomized bench for counter_interact_ctrl against a behavioural kitchen model.
module tb_counter_interact_ctrl;
  import overcooked_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] nearestCounterX = 10'd15;
  logic [9:0] nearestCounterY = 10'd15;
  logic       interactKey = 1'b0;
  logic [3:0] renderSlot = 4'd0;
  logic [2:0] renderItem;
  logic [2:0] heldItem;
  logic       busy;
  logic       serveStrobe;
  logic [7:0] score;

  int n_chk = 0;
  int n_pass = 0;

  item_t m_tab [16];
  item_t m_held;
  int    m_score;

  counter_interact_ctrl dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .nearestCounterX (nearestCounterX),
    .nearestCounterY (nearestCounterY),
    .interactKey     (interactKey),
    .renderSlot      (renderSlot),
    .renderItem      (renderItem),
    .heldItem        (heldItem),
    .busy            (busy),
    .serveStrobe     (serveStrobe),
    .score           (score)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Slot of a counter centre computed arithmetically; -1 when not a top-wall counter.
  function automatic int slot_of(input int x, input int y);
    if (x == 15 && y == 15) return -1;
    if (y != 100 || x < 20) return -1;
    if ((x - 20) % 40 != 0) return -1;
    if ((x - 20) / 40 >= 16) return -1;
    return (x - 20) / 40;
  endfunction

  task automatic model_reset();
    foreach (m_tab[i]) m_tab[i] = ITEM_EMPTY;
    m_held  = ITEM_EMPTY;
    m_score = 0;
  endtask

  task automatic model_act(input int x, input int y, output bit strb);
    int s;
    s = slot_of(x, y);
    strb = 1'b0;
    if (s < 0) begin
    end else if (s == 0) begin
      if (m_held == ITEM_EMPTY) m_held = ITEM_FISH;
    end else if (s == 15) begin
      if (m_held == ITEM_PLATED) begin
        m_held  = ITEM_EMPTY;
        m_score = (m_score >= 255) ? 255 : m_score + 1;
        strb    = 1'b1;
      end
    end else if (m_held == ITEM_EMPTY && m_tab[s] != ITEM_EMPTY) begin
      m_held   = m_tab[s];
      m_tab[s] = ITEM_EMPTY;
    end else if (m_held != ITEM_EMPTY && m_tab[s] == ITEM_EMPTY) begin
      m_tab[s] = m_held;
      m_held   = ITEM_EMPTY;
    end
  endtask

  task automatic do_press(input int x, input int y, input int hold);
    item_t old_held;
    int    s;
    int    n;
    bit    strb;
    @(negedge Clk);
    nearestCounterX = 10'(x);
    nearestCounterY = 10'(y);
    s = slot_of(x, y);
    renderSlot  = (s >= 0) ? 4'(s) : 4'd0;
    interactKey = 1'b1;
    old_held    = m_held;
    @(posedge Clk); #1;
    check("busy_lookup", busy, 1);
    @(posedge Clk); #1;
    check("held_before_k2", heldItem, old_held);
    check("busy_act", busy, 1);
    model_act(x, y, strb);
    @(posedge Clk); #1;
    check("held_k2", heldItem, m_held);
    check("score_k2", score, m_score);
    check("strobe_k2", serveStrobe, strb);
    check("render_k2", renderItem, m_tab[renderSlot]);
    @(posedge Clk); #1;
    check("strobe_pulse_end", serveStrobe, 0);
    check("busy_wait_rel", busy, 1);
    repeat (hold) @(posedge Clk);
    #1;
    check("busy_while_held", busy, 1);
    check("held_single_action", heldItem, m_held);
    @(negedge Clk);
    interactKey = 1'b0;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (busy && n < 5);
    check("idle_after_release", busy, 0);
    check("score_after", score, m_score);
  endtask

  task automatic check_table();
    for (int i = 0; i < 16; i++) begin
      renderSlot = 4'(i);
      #1;
      check("table_slot", renderItem, m_tab[i]);
    end
  endtask

  task automatic set_held(input item_t v);
    @(negedge Clk);
    force dut.held_q = v;
    #1;
    release dut.held_q;
    m_held = v;
  endtask

  task automatic set_score(input int v);
    @(negedge Clk);
    force dut.score_q = 8'(v);
    #1;
    release dut.score_q;
    m_score = v;
  endtask

  task automatic reset_during(input int edges);
    @(negedge Clk);
    nearestCounterX = 10'd100;
    nearestCounterY = 10'd100;
    renderSlot      = 4'd2;
    interactKey     = 1'b1;
    repeat (edges) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_held", heldItem, ITEM_EMPTY);
    check("rst_score", score, 0);
    check("rst_strobe", serveStrobe, 0);
    check("rst_slot2", renderItem, ITEM_EMPTY);
    @(negedge Clk);
    interactKey = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("post_rst_idle", busy, 0);
    check("post_rst_held", heldItem, ITEM_EMPTY);
  endtask

  initial begin
    int x, y, hold;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("reset_held", heldItem, ITEM_EMPTY);
    check("reset_busy", busy, 0);
    check("reset_score", score, 0);
    check("reset_strobe", serveStrobe, 0);
    check("reset_render0", renderItem, ITEM_EMPTY);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    do_press(20, 100, 0);
    check("disp_fish", heldItem, ITEM_FISH);
    do_press(100, 100, 0);
    do_press(100, 100, 0);
    do_press(100, 100, 50);
    do_press(15, 15, 1);
    do_press(110, 100, 0);
    check_table();

    do_press(180, 100, 0);
    set_held(ITEM_PLATED);
    do_press(620, 100, 0);
    check("serve_score1", score, 1);
    set_held(ITEM_FISH);
    do_press(620, 100, 0);
    check("serve_reject_held", heldItem, ITEM_FISH);
    set_score(255);
    set_held(ITEM_PLATED);
    do_press(620, 100, 0);
    check("score_saturated", score, 255);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) set_held(item_t'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) != 0) x = 20 + 40 * int'($urandom_range(0, 16));
      else x = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) != 0) y = 100;
      else y = int'($urandom_range(0, 1023));
      hold = int'($urandom_range(0, 3));
      do_press(x, y, hold);
    end
    check_table();

    set_held(ITEM_COOKED);
    reset_during(1);
    set_held(ITEM_COOKED);
    reset_during(2);
    check_table();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
